// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the M-stage memory access unit.
// Holds the opcode class codes seen on m_op, the access size encoding
// carried in funct3[1:0], the access FSM state type and a helper that
// turns a size code into a byte count.
package mem_access_unit_pkg;

  // Opcode classes (instruction bits [6:2]) that touch data memory
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT2,
    ST_HOLD
  } state_e;

  // A doubleword request on a 32-bit datapath degrades to a word access
  function automatic int size_bytes(input size_e sz, input int xlen);
    case (sz)
      SZ_BYTE:   return 1;
      SZ_HALF:   return 2;
      SZ_WORD:   return 4;
      default:   return (xlen == 64) ? 8 : 4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
//   dm_cs    chip select
//   dm_w_en  active-low byte write enables, all-ones means read
//   dm_addr  word-aligned byte address
//   dm_di    lane-aligned write data
//   dm_ready memory accepts/completes the access this cycle
//   dm_do    read data, meaningful when dm_cs && dm_ready
interface mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              dm_cs;
  logic [NB-1:0]     dm_w_en;
  logic [ADDR_W-1:0] dm_addr;
  logic [XLEN-1:0]   dm_di;
  logic              dm_ready;
  logic [XLEN-1:0]   dm_do;

  modport master (
    output dm_cs, dm_w_en, dm_addr, dm_di,
    input  dm_ready, dm_do
  );

  modport slave (
    input  dm_cs, dm_w_en, dm_addr, dm_di,
    output dm_ready, dm_do
  );
endinterface

// File: rtl/mem_access_unit_byte_lane_gen.sv
// Byte-lane generator for one beat of a possibly split access.
//   off    byte offset of the access inside its word
//   size   access size in bytes
//   second 0 = first beat (lanes off..NB-1), 1 = second beat (lanes 0..)
//   wr     store access; loads keep all write enables high
//   wdata  LSB-justified store data
//   rdata  raw memory word for this beat
//   w_en   active-low byte enables for this beat
//   di     store data moved onto this beat's lanes
//   ld     this beat's load bytes moved to their position in the result
module byte_lane_gen
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [$clog2(XLEN/8):0]   size,
  input  logic                      second,
  input  logic                      wr,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata,
  output logic [XLEN/8-1:0]         w_en,
  output logic [XLEN-1:0]           di,
  output logic [XLEN-1:0]           ld
);
  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  logic [NB-1:0]    mask;
  logic [OFS_W:0]   sh;
  logic [OFS_W+3:0] sh_bits;
  int               lo;
  int               hi;

  // The second beat covers whatever bytes spilled past the word end; its
  // data moves the opposite way to the first beat by the bytes already sent.
  always_comb begin
    lo      = second ? 0 : int'(off);
    hi      = int'(off) + int'(size) - (second ? NB : 0);
    mask    = '0;
    for (int i = 0; i < NB; i++) begin
      mask[i] = (i >= lo) && (i < hi);
    end
    w_en    = wr ? ~mask : '1;
    sh      = second ? ((OFS_W+1)'(NB) - {1'b0, off}) : {1'b0, off};
    sh_bits = {sh, 3'b000};
    di      = second ? (wdata >> sh_bits) : (wdata << sh_bits);
    ld      = second ? (rdata << sh_bits) : (rdata >> sh_bits);
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit. Turns a load/store in the M stage into one or
// two aligned memory beats, stalls the pipeline until the access is done,
// and returns an aligned, extended load result one cycle after completion.
//   clk, rst            clock, synchronous active-high reset
//   m_valid/op/f3       M-stage instruction qualifiers
//   m_addr, m_wdata     effective byte address, store data
//   dm                  data-memory bus (master side)
//   m_stall             hold M stage and upstream
//   m_ld_valid/data     registered load result
//   m_misalign          pulse when a split access completes
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic [4:0]        m_op,
  input  logic [2:0]        m_f3,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [XLEN-1:0]   m_wdata,
  mem_access_unit_if.master dm,
  output logic              m_stall,
  output logic              m_ld_valid,
  output logic [XLEN-1:0]   m_ld_data,
  output logic              m_misalign
);
  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  state_e            state, state_nx;
  logic [XLEN-1:0]   beat1_q;
  logic [ADDR_W-1:0] done_addr_q;

  logic              is_load, is_store, active, split;
  int                nbytes;
  logic [OFS_W:0]    size_w;
  logic [OFS_W-1:0]  off;
  logic [ADDR_W-1:0] word_a, word_b;
  logic [NB-1:0]     w_en1, w_en2;
  logic [XLEN-1:0]   di1, di2, ld1, ld2;
  logic              complete, beat1_done, repeat_acc;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input int nb, input logic zx);
    logic [XLEN-1:0] r;
    logic            fill;
    r    = raw;
    fill = ~zx & raw[8*nb-1];
    for (int i = 0; i < XLEN; i++) begin
      if (i >= 8*nb) r[i] = fill;
    end
    return r;
  endfunction

  assign is_load  = (m_op == OP_LOAD);
  assign is_store = (m_op == OP_STORE);
  assign active   = m_valid && (is_load || is_store) && !rst;
  assign nbytes   = size_bytes(size_e'(m_f3[1:0]), XLEN);
  assign size_w   = (OFS_W+1)'(nbytes);
  assign off      = m_addr[OFS_W-1:0];
  assign split    = ({1'b0, off} + size_w) > (OFS_W+1)'(NB);
  assign word_a   = {m_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign word_b   = word_a + ADDR_W'(NB);

  byte_lane_gen #(.XLEN(XLEN)) u_beat1 (
    .off(off), .size(size_w), .second(1'b0), .wr(is_store),
    .wdata(m_wdata), .rdata(dm.dm_do), .w_en(w_en1), .di(di1), .ld(ld1)
  );

  byte_lane_gen #(.XLEN(XLEN)) u_beat2 (
    .off(off), .size(size_w), .second(1'b1), .wr(is_store),
    .wdata(m_wdata), .rdata(dm.dm_do), .w_en(w_en2), .di(di2), .ld(ld2)
  );

  // HOLD only suppresses the access when the just-finished instruction is
  // still sitting in M (same address); anything else is started as in IDLE.
  assign repeat_acc = (state == ST_HOLD) && (m_addr == done_addr_q);

  always_comb begin
    state_nx   = state;
    dm.dm_cs   = 1'b0;
    dm.dm_w_en = '1;
    dm.dm_addr = word_a;
    dm.dm_di   = di1;
    m_stall    = 1'b0;
    m_misalign = 1'b0;
    complete   = 1'b0;
    beat1_done = 1'b0;
    case (state)
      ST_IDLE, ST_HOLD: begin
        state_nx = ST_IDLE;
        if (active && !repeat_acc) begin
          dm.dm_cs   = 1'b1;
          dm.dm_w_en = w_en1;
          if (!dm.dm_ready) begin
            m_stall = 1'b1;
          end else if (split) begin
            m_stall    = 1'b1;
            beat1_done = 1'b1;
            state_nx   = ST_BEAT2;
          end else begin
            complete = 1'b1;
            state_nx = is_store ? ST_HOLD : ST_IDLE;
          end
        end
      end
      ST_BEAT2: begin
        if (active) begin
          dm.dm_cs   = 1'b1;
          dm.dm_w_en = w_en2;
          dm.dm_addr = word_b;
          dm.dm_di   = di2;
          if (dm.dm_ready) begin
            complete   = 1'b1;
            m_misalign = 1'b1;
            state_nx   = ST_IDLE;
          end else begin
            m_stall = 1'b1;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, first-beat load bytes and the registered load result
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      beat1_q     <= '0;
      done_addr_q <= '0;
      m_ld_valid  <= 1'b0;
      m_ld_data   <= '0;
    end else begin
      state      <= state_nx;
      m_ld_valid <= complete && is_load;
      if (beat1_done) beat1_q <= ld1;
      if (complete) done_addr_q <= m_addr;
      if (complete && is_load) begin
        m_ld_data <= extend((state == ST_BEAT2) ? (beat1_q | ld2) : ld1,
                            nbytes, m_f3[2]);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (XLEN=32). Stimulus pushes the
// expected memory beats and load results; a negedge monitor pops and
// compares them whenever the DUT completes a beat or presents a load.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] di;
    bit          chk_di;
    bit          stall;
    bit          mis;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [4:0]  m_op;
  logic [2:0]  m_f3;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_stall, m_ld_valid, m_misalign;
  logic [31:0] m_ld_data;
  logic        ready;
  logic [31:0] mem [0:255];

  beat_t       exp_beats[$];
  logic [31:0] exp_loads[$];
  beat_t       mon_b;
  logic [31:0] mon_l;
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) dm_bus ();

  mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_op(m_op), .m_f3(m_f3),
    .m_addr(m_addr), .m_wdata(m_wdata), .dm(dm_bus.master),
    .m_stall(m_stall), .m_ld_valid(m_ld_valid), .m_ld_data(m_ld_data),
    .m_misalign(m_misalign)
  );

  assign dm_bus.dm_ready = ready;
  assign dm_bus.dm_do    = mem[dm_bus.dm_addr[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (dm_bus.dm_cs && dm_bus.dm_ready) begin
      for (int i = 0; i < 4; i++)
        if (!dm_bus.dm_w_en[i])
          mem[dm_bus.dm_addr[9:2]][8*i +: 8] <= dm_bus.dm_di[8*i +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectBeat(input logic [31:0] a, input logic [3:0] w,
                            input logic [31:0] d, input bit cd,
                            input bit st, input bit mi);
    beat_t b;
    b = '{addr: a, wen: w, di: d, chk_di: cd, stall: st, mis: mi};
    exp_beats.push_back(b);
  endtask

  // Monitor: every completed beat and every load result is scored
  always @(negedge clk) begin
    if (dm_bus.dm_cs && dm_bus.dm_ready) begin
      if (exp_beats.size() == 0) begin
        checkOutput("unexpected_beat_addr", {32'h0, dm_bus.dm_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_b = exp_beats.pop_front();
        checkOutput("beat_addr", {32'h0, dm_bus.dm_addr}, {32'h0, mon_b.addr});
        checkOutput("beat_w_en", {60'h0, dm_bus.dm_w_en}, {60'h0, mon_b.wen});
        if (mon_b.chk_di)
          checkOutput("beat_di", {32'h0, dm_bus.dm_di}, {32'h0, mon_b.di});
        checkOutput("beat_stall", {63'h0, m_stall}, {63'h0, mon_b.stall});
        checkOutput("beat_misalign", {63'h0, m_misalign}, {63'h0, mon_b.mis});
      end
    end
    if (m_ld_valid) begin
      if (exp_loads.size() == 0) begin
        checkOutput("unexpected_load", {32'h0, m_ld_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_l = exp_loads.pop_front();
        checkOutput("ld_data", {32'h0, m_ld_data}, {32'h0, mon_l});
      end
    end
  end

  // Drive one access, wait (bounded) until it completes, then idle a cycle
  task automatic applyStimulus(input logic [4:0] op, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd);
    bit done;
    done    = 0;
    m_valid = 1'b1;
    m_op    = op;
    m_f3    = f3;
    m_addr  = addr;
    m_wdata = wd;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!m_stall) done = 1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL completion_timeout: addr 0x%0h never completed", addr);
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; m_valid = 1'b0; m_op = OP_LOAD; m_f3 = 3'b010;
    m_addr = 32'h0; m_wdata = 32'h0; ready = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b1; m_op = OP_STORE; m_addr = 32'h100;
    @(negedge clk);
    checkOutput("rst_dm_cs", {63'h0, dm_bus.dm_cs}, 64'h0);
    checkOutput("rst_w_en", {60'h0, dm_bus.dm_w_en}, 64'hF);
    @(posedge clk); #1;
    rst = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_ld_valid", {63'h0, m_ld_valid}, 64'h0);
    checkOutput("rst_ld_data", {32'h0, m_ld_data}, 64'h0);
    checkOutput("rst_misalign", {63'h0, m_misalign}, 64'h0);
    checkOutput("rst_stall", {63'h0, m_stall}, 64'h0);
    @(posedge clk); #1;

    // Aligned and single-beat stores
    expectBeat(32'h100, 4'b0000, 32'hDEADBEEF, 1, 0, 0);
    applyStimulus(OP_STORE, 3'b010, 32'h100, 32'hDEADBEEF);
    expectBeat(32'h100, 4'b0111, 32'hAB000000, 1, 0, 0);
    applyStimulus(OP_STORE, 3'b000, 32'h103, 32'h000000AB);
    // Split word store
    expectBeat(32'h100, 4'b0011, 32'h33440000, 1, 1, 0);
    expectBeat(32'h104, 4'b1100, 32'h00001122, 1, 0, 1);
    applyStimulus(OP_STORE, 3'b010, 32'h102, 32'h11223344);
    // Set up mem[0x100]=0x8044BEEF, mem[0x104]=0x0000117F
    expectBeat(32'h100, 4'b0111, 32'h80000000, 1, 0, 0);
    applyStimulus(OP_STORE, 3'b000, 32'h103, 32'h00000080);
    expectBeat(32'h104, 4'b1110, 32'h0000007F, 1, 0, 0);
    applyStimulus(OP_STORE, 3'b000, 32'h104, 32'h0000007F);
    // Split halfword load
    expectBeat(32'h100, 4'b1111, 32'h0, 0, 1, 0);
    expectBeat(32'h104, 4'b1111, 32'h0, 0, 0, 1);
    exp_loads.push_back(32'h00007F80);
    applyStimulus(OP_LOAD, 3'b001, 32'h103, 32'h0);
    // mem[0x100] becomes 0x804480FF
    expectBeat(32'h100, 4'b1100, 32'h000080FF, 1, 0, 0);
    applyStimulus(OP_STORE, 3'b001, 32'h100, 32'h000080FF);
    expectBeat(32'h100, 4'b1111, 32'h0, 0, 0, 0);
    exp_loads.push_back(32'hFFFF80FF);
    applyStimulus(OP_LOAD, 3'b001, 32'h100, 32'h0);
    expectBeat(32'h100, 4'b1111, 32'h0, 0, 0, 0);
    exp_loads.push_back(32'h000080FF);
    applyStimulus(OP_LOAD, 3'b101, 32'h100, 32'h0);
    expectBeat(32'h100, 4'b1111, 32'h0, 0, 0, 0);
    exp_loads.push_back(32'hFFFFFF80);
    applyStimulus(OP_LOAD, 3'b000, 32'h101, 32'h0);
    expectBeat(32'h100, 4'b1111, 32'h0, 0, 0, 0);
    exp_loads.push_back(32'h00000044);
    applyStimulus(OP_LOAD, 3'b100, 32'h102, 32'h0);
    expectBeat(32'h100, 4'b1111, 32'h0, 0, 0, 0);
    exp_loads.push_back(32'h804480FF);
    applyStimulus(OP_LOAD, 3'b010, 32'h100, 32'h0);
    // Split word load across 0x100/0x104
    expectBeat(32'h100, 4'b1111, 32'h0, 0, 1, 0);
    expectBeat(32'h104, 4'b1111, 32'h0, 0, 0, 1);
    exp_loads.push_back(32'h7F804480);
    applyStimulus(OP_LOAD, 3'b010, 32'h101, 32'h0);
    // Address wrap on the second beat
    expectBeat(32'hFFFFFFFC, 4'b0011, 32'hF00D0000, 1, 1, 0);
    expectBeat(32'h00000000, 4'b1100, 32'h0000CAFE, 1, 0, 1);
    applyStimulus(OP_STORE, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D);

    // Non-memory opcode is ignored
    m_valid = 1'b1; m_op = 5'b01100; m_f3 = 3'b010; m_addr = 32'h200;
    @(negedge clk);
    checkOutput("nonmem_cs", {63'h0, dm_bus.dm_cs}, 64'h0);
    checkOutput("nonmem_w_en", {60'h0, dm_bus.dm_w_en}, 64'hF);
    checkOutput("nonmem_stall", {63'h0, m_stall}, 64'h0);
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(posedge clk); #1;

    // Split store with memory stalling three cycles on beat 2
    expectBeat(32'h100, 4'b0011, 32'h77880000, 1, 1, 0);
    m_valid = 1'b1; m_op = OP_STORE; m_f3 = 3'b010;
    m_addr = 32'h102; m_wdata = 32'h55667788;
    @(posedge clk); #1;
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("wait_stall", {63'h0, m_stall}, 64'h1);
      checkOutput("wait_cs", {63'h0, dm_bus.dm_cs}, 64'h1);
      checkOutput("wait_addr", {32'h0, dm_bus.dm_addr}, 64'h104);
      checkOutput("wait_w_en", {60'h0, dm_bus.dm_w_en}, 64'hC);
      checkOutput("wait_di", {32'h0, dm_bus.dm_di}, 64'h00005566);
      @(posedge clk); #1;
    end
    expectBeat(32'h104, 4'b1100, 32'h00005566, 1, 0, 1);
    ready = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while in BEAT2: second beat must never appear
    expectBeat(32'h104, 4'b0011, 32'hBBCC0000, 1, 1, 0);
    m_valid = 1'b1; m_op = OP_STORE; m_f3 = 3'b010;
    m_addr = 32'h106; m_wdata = 32'h99AABBCC;
    @(posedge clk); #1;
    rst = 1'b1; m_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstb2_cs", {63'h0, dm_bus.dm_cs}, 64'h0);
    checkOutput("rstb2_w_en", {60'h0, dm_bus.dm_w_en}, 64'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("post_rst_cs", {63'h0, dm_bus.dm_cs}, 64'h0);
      checkOutput("post_rst_stall", {63'h0, m_stall}, 64'h0);
    end
    checkOutput("post_rst_ld_valid", {63'h0, m_ld_valid}, 64'h0);

    checkOutput("beats_left", 64'(exp_beats.size()), 64'h0);
    checkOutput("loads_left", 64'(exp_loads.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
